// File: rtl/maj_voter_nch.sv
// Registered bitwise N-channel majority voter with per-channel disagreement
// counters, sticky fault flags and optional exclusion of faulted channels.
module maj_voter_nch #(
  parameter int N_IN        = 3,
  parameter int WIDTH       = 8,
  parameter int CNT_W       = 4,
  parameter int FAULT_THR   = 3,
  parameter bit MASK_FAULTY = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [N_IN*WIDTH-1:0]   in_data,
  input  logic                    clr_fault,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_unan,
  output logic                    no_quorum,
  output logic [N_IN-1:0]         fault_flag,
  output logic [N_IN*CNT_W-1:0]   dis_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_IN-1:0]         act;
  logic [N_IN-1:0]         dis;
  logic [WIDTH-1:0]        vote;
  logic                    unan;
  int                      na;
  int                      ones;
  logic [CNT_W-1:0]        c_cur;
  logic [CNT_W-1:0]        c_upd;
  logic [N_IN*CNT_W-1:0]   cnt_nxt;
  logic [N_IN-1:0]         flag_nxt;

  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    act      = MASK_FAULTY ? ~fault_flag : '1;
    na       = 0;
    ones     = 0;
    vote     = '0;
    unan     = 1'b0;
    dis      = '0;
    c_cur    = '0;
    c_upd    = '0;
    cnt_nxt  = dis_cnt;
    flag_nxt = fault_flag;

    for (int i = 0; i < N_IN; i++) begin
      if (act[i]) na = na + 1;
    end

    // Strict majority of the active channels; a tie (or no channel at all) votes 0.
    for (int b = 0; b < WIDTH; b++) begin
      ones = 0;
      for (int i = 0; i < N_IN; i++) begin
        if (act[i] && in_data[i*WIDTH+b]) ones = ones + 1;
      end
      vote[b] = (2 * ones > na);
    end

    unan = (na != 0);
    for (int i = 0; i < N_IN; i++) begin
      if (act[i] && (in_data[i*WIDTH +: WIDTH] != vote)) begin
        dis[i] = 1'b1;
        unan   = 1'b0;
      end
    end

    // Masked channels keep their count; their flag is already set.
    for (int i = 0; i < N_IN; i++) begin
      c_cur = dis_cnt[i*CNT_W +: CNT_W];
      if (dis[i])
        c_upd = (c_cur == CNT_MAX) ? c_cur : c_cur + CNT_W'(1);
      else if (act[i])
        c_upd = '0;
      else
        c_upd = c_cur;
      cnt_nxt[i*CNT_W +: CNT_W] = c_upd;
      if (int'(c_upd) >= FAULT_THR) flag_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_unan   <= 1'b0;
      no_quorum  <= 1'b0;
      fault_flag <= '0;
      dis_cnt    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      out_valid <= in_valid;
      if (in_valid) begin
        out_data  <= vote;
        out_unan  <= unan;
        no_quorum <= (na == 0);
      end
      // A clear wins over the counter update of a simultaneous sample.
      if (clr_fault) begin
        dis_cnt    <= '0;
        fault_flag <= '0;
      end else if (in_valid) begin
        dis_cnt    <= cnt_nxt;
        fault_flag <= flag_nxt;
      end
    end
  end

endmodule

// File: tb/tb_maj_voter_nch.sv
// Scoreboard bench for maj_voter_nch: two instances (masking on/off) share
// stimulus; a reference model predicts each response, a monitor compares.
module tb_maj_voter_nch;

  typedef struct {
    logic [7:0]  data;
    logic        unan;
    logic        nq;
    logic [2:0]  flags;
    logic [11:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [23:0] in_data;
  logic        clr_fault;

  logic [1:0]  ov;
  logic [7:0]  od [2];
  logic [1:0]  ou;
  logic [1:0]  nq;
  logic [2:0]  ff [2];
  logic [11:0] dc [2];

  int tests = 0;
  int fails = 0;

  exp_t q0[$];
  exp_t q1[$];
  logic [9:0] last [2];

  int m_cnt  [2][3];
  bit m_flag [2][3];

  always #5 clk = ~clk;

  maj_voter_nch u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .clr_fault(clr_fault), .out_valid(ov[0]), .out_data(od[0]), .out_unan(ou[0]),
    .no_quorum(nq[0]), .fault_flag(ff[0]), .dis_cnt(dc[0])
  );

  maj_voter_nch #(.MASK_FAULTY(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .clr_fault(clr_fault), .out_valid(ov[1]), .out_data(od[1]), .out_unan(ou[1]),
    .no_quorum(nq[1]), .fault_flag(ff[1]), .dis_cnt(dc[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void clear_models();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 3; i++) begin
        m_cnt[k][i]  = 0;
        m_flag[k][i] = 1'b0;
      end
  endfunction

  // Instance 0 excludes faulted channels, instance 1 always counts everyone.
  function automatic exp_t model_step(int k, logic [23:0] d, bit clr);
    exp_t       e;
    logic [7:0] w [3];
    bit         active [3];
    int         n_act;
    logic [7:0] v;
    bit         un;
    n_act = 0;
    for (int i = 0; i < 3; i++) begin
      w[i]      = d[i*8 +: 8];
      active[i] = (k == 0) ? !m_flag[k][i] : 1'b1;
      if (active[i]) n_act++;
    end
    for (int b = 0; b < 8; b++) begin
      int o = 0;
      int z = 0;
      for (int i = 0; i < 3; i++)
        if (active[i]) begin
          if (w[i][b]) o++; else z++;
        end
      v[b] = (o > z);
    end
    un = (n_act > 0);
    for (int i = 0; i < 3; i++)
      if (active[i] && w[i] != v) un = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (clr) begin
        m_cnt[k][i]  = 0;
        m_flag[k][i] = 1'b0;
      end else if (active[i]) begin
        if (w[i] != v) m_cnt[k][i] = (m_cnt[k][i] >= 15) ? 15 : m_cnt[k][i] + 1;
        else           m_cnt[k][i] = 0;
        if (m_cnt[k][i] >= 3) m_flag[k][i] = 1'b1;
      end
    end
    e.data  = v;
    e.unan  = un;
    e.nq    = (n_act == 0);
    e.flags = {m_flag[k][2], m_flag[k][1], m_flag[k][0]};
    e.cnt   = {m_cnt[k][2][3:0], m_cnt[k][1][3:0], m_cnt[k][0][3:0]};
    return e;
  endfunction

  task automatic drive(input bit v, input logic [23:0] d, input bit clr);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    clr_fault = clr;
    if (v) begin
      q0.push_back(model_step(0, d, clr));
      q1.push_back(model_step(1, d, clr));
    end else if (clr) begin
      clear_models();
    end
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < 2; k++)
      check($sformatf("%s reset outputs u%0d", tag, k),
            {ov[k], od[k], ou[k], nq[k], ff[k], dc[k]}, 32'h0);
  endtask

  // Reset lands right after the edge that captured the pending sample, dropping it.
  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    clr_fault = 1'b0;
    q0.delete();
    q1.delete();
    clear_models();
    #1;
    check_zero("mid-stream");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic mon(input int k);
    exp_t e;
    bit   have;
    string p;
    p = $sformatf("u%0d", k);
    if (!rst_n) begin
      last[k] = '0;
    end else if (ov[k]) begin
      have = 1'b0;
      if (k == 0) begin
        if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      end else begin
        if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      end
      if (!have) begin
        check({p, " unexpected out_valid"}, 32'd1, 32'd0);
      end else begin
        check({p, " out_data"},   {24'h0, od[k]}, {24'h0, e.data});
        check({p, " out_unan"},   {31'h0, ou[k]}, {31'h0, e.unan});
        check({p, " no_quorum"},  {31'h0, nq[k]}, {31'h0, e.nq});
        check({p, " fault_flag"}, {29'h0, ff[k]}, {29'h0, e.flags});
        check({p, " dis_cnt"},    {20'h0, dc[k]}, {20'h0, e.cnt});
        last[k] = {e.data, e.unan, e.nq};
      end
    end else begin
      check({p, " idle hold"}, {22'h0, od[k], ou[k], nq[k]}, {22'h0, last[k]});
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  base;
    logic [23:0] d;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    clr_fault = 1'b0;
    last[0]   = '0;
    last[1]   = '0;
    clear_models();
    #1;
    check_zero("power-on");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Unanimous, then a pure bitwise vote.
    drive(1, {8'hA5, 8'hA5, 8'hA5}, 0);
    drive(1, {8'hAA, 8'hCC, 8'hF0}, 0);
    drive(1, {8'h3C, 8'h3C, 8'h3C}, 0);
    // Channel 2 faults after three disagreements, then is masked out.
    repeat (3) drive(1, {8'h00, 8'h3C, 8'h3C}, 0);
    drive(1, {8'hFF, 8'h3C, 8'h3C}, 0);
    // Two active channels: ties vote 0; channel 0 then faults.
    drive(1, {8'h55, 8'hFF, 8'h0F}, 0);
    repeat (3) drive(1, {8'h55, 8'h0F, 8'hFF}, 0);
    drive(1, {8'h56, 8'h34, 8'h12}, 0);
    // Clear alone, then all three fault on the same edge, then no quorum.
    drive(0, 24'h0, 1);
    repeat (3) drive(1, {8'hAA, 8'hCC, 8'hF0}, 0);
    drive(1, {8'h77, 8'h66, 8'h99}, 0);
    // Clear with a simultaneous sample, voted with the old mask.
    drive(1, {8'h81, 8'h81, 8'h18}, 1);
    // Mid-count disagreement that recovers.
    repeat (2) drive(1, {8'h00, 8'h3C, 8'h3C}, 0);
    drive(1, {8'h3C, 8'h3C, 8'h3C}, 0);
    drive(0, 24'h0, 0);

    // Reset between two valid samples.
    drive(1, {8'h11, 8'h22, 8'h11}, 0);
    pulse_reset();
    drive(1, {8'h42, 8'h42, 8'h40}, 0);

    // Randomised traffic: channels mostly agree, with occasional outliers.
    for (int n = 0; n < 600; n++) begin
      base = 8'($urandom);
      for (int i = 0; i < 3; i++)
        d[i*8 +: 8] = ($urandom_range(0, 3) != 0) ? base : 8'($urandom);
      drive($urandom_range(0, 4) != 0, d, $urandom_range(0, 40) == 0);
    end
    drive(0, 24'h0, 0);

    for (int i = 0; i < 20 && (q0.size() + q1.size()) != 0; i++) @(posedge clk);
    check("scoreboard drained", q0.size() + q1.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
